// File: rtl/move_list_collector_if.sv
// move_list_collector_if
//   Bundles the column-side and consumer-side signals of the move list
//   collector.
//   slave  : seen by the collector (start/col_done/col_fifo_out/move_ready in,
//            col_rden/move_out/move_valid/move_count/busy/done out)
//   master : seen by the environment driving the collector
interface move_list_collector_if #(
   parameter int NCOL  = 8,
   parameter int SLOTS = 8,
   parameter int MW    = 19
);
   logic                       start;
   logic [NCOL-1:0]            col_done;
   logic [NCOL*SLOTS*MW-1:0]   col_fifo_out;
   logic [NCOL-1:0]            col_rden;
   logic [MW-1:0]              move_out;
   logic                       move_valid;
   logic                       move_ready;
   logic [7:0]                 move_count;
   logic                       busy;
   logic                       done;

   modport slave (
      input  start, col_done, col_fifo_out, move_ready,
      output col_rden, move_out, move_valid, move_count, busy, done
   );

   modport master (
      output start, col_done, col_fifo_out, move_ready,
      input  col_rden, move_out, move_valid, move_count, busy, done
   );
endinterface

// File: rtl/move_list_collector.sv
// move_list_collector
//   Drains the per-column move FIFOs once each column reports done, unpacks
//   every FIFO word into SLOTS move records, drops invalid slots and streams
//   the legal moves one at a time over a valid/ready handshake.
//   clk, reset : clock, asynchronous active-high reset
//   bus.start        : one-cycle pulse, begins collection (IDLE/DONE only)
//   bus.col_done     : per-column generator finished
//   bus.col_fifo_out : all column FIFO heads, column c at [WW*c +: WW]
//   bus.col_rden     : one-hot FIFO read pulse
//   bus.move_out/move_valid/move_ready : move stream to the consumer
//   bus.move_count   : accepted moves this position, saturating at 255
//   bus.busy/done    : collection in progress / all columns drained
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_SEL    | choose lowest done-but-not-grabbed column, or finish
// S_RDREQ  | one-cycle read pulse to the chosen column FIFO
// S_WAITD  | wait RD_LAT cycles, capture word or detect end marker
// S_UNPACK | examine one slot per cycle, hold valid moves until accepted
// S_DONE   | all columns drained; start re-arms
module move_list_collector #(
   parameter int NCOL   = 8,
   parameter int SLOTS  = 8,
   parameter int MW     = 19,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   move_list_collector_if.slave bus
);

   localparam int WW = SLOTS * MW;
   localparam int CW = (NCOL  > 1) ? $clog2(NCOL)  : 1;
   localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_RDREQ,
      S_WAITD,
      S_UNPACK,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [NCOL-1:0]   r_grabbed;
   logic [CW-1:0]     r_col;
   logic [PW-1:0]     r_ptr;
   logic [WW-1:0]     r_word;
   logic [7:0]        r_count;
   logic [LW-1:0]     r_lat;

   logic              w_all_grabbed;
   logic              w_pick_ok;
   logic [CW-1:0]     w_pick_idx;
   logic [WW-1:0]     w_in_word;
   logic              w_end_mark;
   logic [MW-1:0]     w_slot;
   logic              w_valid;
   logic              w_accept;
   logic              w_slot_done;
   logic              w_last_slot;
   logic              w_lat_tc;
   logic              w_start_ok;

   assign w_all_grabbed = &r_grabbed;

   // Descending scan so the last hit, and therefore the winner, is the
   // lowest-index ready column.
   always_comb begin
      w_pick_ok  = 1'b0;
      w_pick_idx = '0;
      for (int c = NCOL - 1; c >= 0; c--) begin
         if (bus.col_done[c] && !r_grabbed[c]) begin
            w_pick_ok  = 1'b1;
            w_pick_idx = CW'(c);
         end
      end
   end

   assign w_in_word = bus.col_fifo_out[int'(r_col) * WW +: WW];

   // A word with every slot flagged invalid marks the end of the column.
   always_comb begin
      w_end_mark = 1'b1;
      for (int k = 0; k < SLOTS; k++) begin
         w_end_mark = w_end_mark & w_in_word[k * MW + MW - 1];
      end
   end

   assign w_slot      = r_word[int'(r_ptr) * MW +: MW];
   assign w_valid     = (r_state == S_UNPACK) && !w_slot[MW-1];
   assign w_accept    = w_valid && bus.move_ready;
   // A slot is finished when it is skipped or its move is accepted.
   assign w_slot_done = (r_state == S_UNPACK) && (w_slot[MW-1] || bus.move_ready);
   assign w_last_slot = (r_ptr == PW'(SLOTS - 1));
   assign w_lat_tc    = (r_lat == '0);
   assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_SEL;
         end
         S_SEL: begin
            if (w_all_grabbed)  w_next = S_DONE;
            else if (w_pick_ok) w_next = S_RDREQ;
         end
         S_RDREQ: begin
            w_next = S_WAITD;
         end
         S_WAITD: begin
            if (w_lat_tc) w_next = w_end_mark ? S_SEL : S_UNPACK;
         end
         S_UNPACK: begin
            if (w_slot_done && w_last_slot) w_next = S_RDREQ;
         end
         S_DONE: begin
            if (bus.start) w_next = S_SEL;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grabbed <= '0;
         r_col     <= '0;
         r_ptr     <= '0;
         r_word    <= '0;
         r_count   <= '0;
         r_lat     <= '0;
      end else begin
         if (w_start_ok) begin
            r_grabbed <= '0;
            r_count   <= '0;
         end

         if ((r_state == S_SEL) && !w_all_grabbed && w_pick_ok) begin
            r_col <= w_pick_idx;
         end

         if (r_state == S_RDREQ) begin
            r_lat <= LW'(RD_LAT - 1);
         end

         if (r_state == S_WAITD) begin
            if (!w_lat_tc) begin
               r_lat <= r_lat - 1'b1;
            end else if (w_end_mark) begin
               r_grabbed[r_col] <= 1'b1;
            end else begin
               r_word <= w_in_word;
               r_ptr  <= '0;
            end
         end

         if (w_slot_done) begin
            r_ptr <= w_last_slot ? '0 : r_ptr + 1'b1;
         end

         if (w_accept && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
         end
      end
   end

   // Outputs decode straight from registered state so an asynchronous reset
   // clears them immediately.
   assign bus.col_rden   = (r_state == S_RDREQ) ? (NCOL'(1) << r_col) : '0;
   assign bus.move_valid = w_valid;
   assign bus.move_out   = w_valid ? w_slot : '0;
   assign bus.move_count = r_count;
   assign bus.busy       = (r_state == S_SEL) || (r_state == S_RDREQ) ||
                           (r_state == S_WAITD) || (r_state == S_UNPACK);
   assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_move_list_collector.sv
// tb_move_list_collector
//   Directed bench for move_list_collector: column FIFO models fed from
//   per-column queues (empty queue returns an end marker), a move monitor and
//   hand-computed expectations.
module tb_move_list_collector;

   localparam int NCOL  = 8;
   localparam int SLOTS = 8;
   localparam int MW    = 19;
   localparam int WW    = SLOTS * MW;
   localparam logic [MW-1:0] INV = 19'h40000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   move_list_collector_if #(.NCOL(NCOL), .SLOTS(SLOTS), .MW(MW)) bus ();

   move_list_collector #(.NCOL(NCOL), .SLOTS(SLOTS), .MW(MW), .RD_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [WW-1:0]      colq [NCOL][$];
   logic [NCOL*WW-1:0] fifo_bus  = '0;
   logic [NCOL-1:0]    pend_rden = '0;
   int                 rd_log[$];
   logic [MW-1:0]      rx[$];

   assign bus.col_fifo_out = fifo_bus;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] end_word();
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < SLOTS; k++) w[k*MW +: MW] = INV;
      return w;
   endfunction

   function automatic logic [WW-1:0] seq_word(input int base, input int n);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < SLOTS; k++) w[k*MW +: MW] = (k < n) ? MW'(base + k) : INV;
      return w;
   endfunction

   function automatic logic [MW-1:0] mv(input int from, input int to);
      return MW'(from * 64 + to);
   endfunction

   function automatic logic [31:0] rx_at(input int i);
      if (i < rx.size()) return 32'(rx[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int log_at(input int i);
      if (i < rd_log.size()) return rd_log[i];
      return -1;
   endfunction

   function automatic int count_reads(input int c);
      int n;
      n = 0;
      foreach (rd_log[i]) if (rd_log[i] == c) n++;
      return n;
   endfunction

   // Column FIFO model: data appears one cycle after the read pulse.
   always @(posedge clk) begin
      for (int c = 0; c < NCOL; c++) begin
         if (pend_rden[c] && !reset) begin
            if (colq[c].size() > 0) fifo_bus[c*WW +: WW] <= colq[c].pop_front();
            else                    fifo_bus[c*WW +: WW] <= end_word();
         end
      end
   end

   always @(negedge clk) begin
      pend_rden = bus.col_rden;
      if (bus.col_rden != '0) begin
         check_val("rden_onehot", 32'($countones(bus.col_rden)), 32'd1);
         for (int c = 0; c < NCOL; c++) begin
            if (bus.col_rden[c]) begin
               check_val("rden_gated", 32'(bus.col_done[c]), 32'd1);
               rd_log.push_back(c);
            end
         end
      end
      if (bus.move_valid && bus.move_ready) rx.push_back(bus.move_out);
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!bus.done && n < lim) begin
         @(negedge clk);
         n++;
      end
      check_val("done_seen", 32'(bus.done), 32'd1);
   endtask

   task automatic wait_valid(input int lim);
      int n;
      n = 0;
      while (!bus.move_valid && n < lim) begin
         @(negedge clk);
         n++;
      end
      check_val("valid_seen", 32'(bus.move_valid), 32'd1);
   endtask

   task automatic clear_all();
      for (int c = 0; c < NCOL; c++) colq[c].delete();
      rx.delete();
      rd_log.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WW-1:0] w1;
      int            lat;
      int            n;
      int            exp_log[11];

      bus.start      = 1'b0;
      bus.col_done   = '0;
      bus.move_ready = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_rden",  32'(bus.col_rden),   32'd0);
      check_val("rst_valid", 32'(bus.move_valid), 32'd0);
      check_val("rst_out",   32'(bus.move_out),   32'd0);
      check_val("rst_count", 32'(bus.move_count), 32'd0);
      check_val("rst_busy",  32'(bus.busy),       32'd0);
      check_val("rst_done",  32'(bus.done),       32'd0);
      @(negedge clk);
      reset = 1'b0;

      // single column, three moves, ready tied high
      w1 = end_word();
      w1[0*MW +: MW] = mv(8, 16);
      w1[1*MW +: MW] = mv(8, 24);
      w1[2*MW +: MW] = mv(8, 25);
      clear_all();
      colq[0].push_back(w1);
      bus.col_done   = '1;
      bus.move_ready = 1'b1;
      pulse_start();
      check_val("t1_busy", 32'(bus.busy), 32'd1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.move_valid && lat < 50);
      check_val("t1_latency", 32'(lat), 32'd4);
      check_val("t1_first",   32'(bus.move_out), 32'(mv(8, 16)));
      wait_done(200);
      check_val("t1_nmoves", 32'(rx.size()), 32'd3);
      check_val("t1_mv0", rx_at(0), 32'(mv(8, 16)));
      check_val("t1_mv1", rx_at(1), 32'(mv(8, 24)));
      check_val("t1_mv2", rx_at(2), 32'(mv(8, 25)));
      check_val("t1_count", 32'(bus.move_count), 32'd3);
      check_val("t1_busy_end", 32'(bus.busy), 32'd0);
      check_val("t1_col0_reads", 32'(count_reads(0)), 32'd2);
      check_val("t1_total_reads", 32'(rd_log.size()), 32'd9);

      // backpressure on the first move
      clear_all();
      colq[0].push_back(w1);
      bus.move_ready = 1'b0;
      pulse_start();
      wait_valid(50);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("t2_hold_valid", 32'(bus.move_valid), 32'd1);
         check_val("t2_hold_out",   32'(bus.move_out),   32'(mv(8, 16)));
         check_val("t2_hold_count", 32'(bus.move_count), 32'd0);
      end
      @(posedge clk);
      #1 bus.move_ready = 1'b1;
      wait_done(200);
      check_val("t2_nmoves", 32'(rx.size()), 32'd3);
      check_val("t2_mv0", rx_at(0), 32'(mv(8, 16)));
      check_val("t2_mv2", rx_at(2), 32'(mv(8, 25)));
      check_val("t2_count", 32'(bus.move_count), 32'd3);

      // out-of-order column completion
      clear_all();
      colq[5].push_back(seq_word(100, 8));
      colq[5].push_back(seq_word(108, 8));
      colq[2].push_back(seq_word(200, 2));
      bus.col_done = 8'h20;
      pulse_start();
      repeat (9) @(posedge clk);
      #1;
      check_val("t3_mid_word", 32'(bus.move_valid), 32'd1);
      bus.col_done = 8'h24;
      repeat (40) @(posedge clk);
      #1 bus.col_done = '1;
      wait_done(400);
      exp_log = '{5, 5, 5, 2, 2, 0, 1, 3, 4, 6, 7};
      check_val("t3_nreads", 32'(rd_log.size()), 32'd11);
      for (int i = 0; i < 11; i++) check_val("t3_order", 32'(log_at(i)), 32'(exp_log[i]));
      check_val("t3_nmoves", 32'(rx.size()), 32'd18);
      for (int i = 0; i < 16; i++) check_val("t3_col5_mv", rx_at(i), 32'(100 + i));
      check_val("t3_col2_mv0", rx_at(16), 32'd200);
      check_val("t3_col2_mv1", rx_at(17), 32'd201);
      check_val("t3_count", 32'(bus.move_count), 32'd18);

      // move_count saturation with 260 moves
      clear_all();
      for (int w = 0; w < 16; w++) colq[0].push_back(seq_word(8 * w, 8));
      for (int w = 0; w < 16; w++) colq[1].push_back(seq_word(128 + 8 * w, 8));
      colq[2].push_back(seq_word(256, 4));
      pulse_start();
      wait_done(3000);
      check_val("t4_count_sat", 32'(bus.move_count), 32'd255);
      check_val("t4_nmoves", 32'(rx.size()), 32'd260);
      for (int i = 0; i < 260; i++) check_val("t4_mv", rx_at(i), 32'(i));

      // asynchronous reset during a valid move
      clear_all();
      colq[0].push_back(seq_word(300, 8));
      colq[0].push_back(seq_word(308, 8));
      pulse_start();
      n = 0;
      while (bus.move_count < 8'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("t5_pre_valid", 32'(bus.move_valid), 32'd1);
      check_val("t5_pre_count", 32'(bus.move_count), 32'd3);
      #2 reset = 1'b1;
      #1;
      check_val("t5_rst_valid", 32'(bus.move_valid), 32'd0);
      check_val("t5_rst_rden",  32'(bus.col_rden),   32'd0);
      check_val("t5_rst_count", 32'(bus.move_count), 32'd0);
      check_val("t5_rst_busy",  32'(bus.busy),       32'd0);
      check_val("t5_rst_out",   32'(bus.move_out),   32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rd_log.delete();
      repeat (6) @(negedge clk);
      check_val("t5_post_reads", 32'(rd_log.size()), 32'd0);
      check_val("t5_post_done",  32'(bus.done),      32'd0);
      check_val("t5_post_busy",  32'(bus.busy),      32'd0);
      check_val("t5_post_valid", 32'(bus.move_valid), 32'd0);

      // restart from DONE repeats the collection
      clear_all();
      colq[0].push_back(seq_word(400, 8));
      colq[1].push_back(seq_word(408, 4));
      pulse_start();
      wait_done(200);
      check_val("t6_count_a", 32'(bus.move_count), 32'd12);
      check_val("t6_nmoves_a", 32'(rx.size()), 32'd12);
      clear_all();
      colq[0].push_back(seq_word(400, 8));
      colq[1].push_back(seq_word(408, 4));
      pulse_start();
      check_val("t6_restart_done",  32'(bus.done),       32'd0);
      check_val("t6_restart_count", 32'(bus.move_count), 32'd0);
      check_val("t6_restart_busy",  32'(bus.busy),       32'd1);
      wait_done(200);
      check_val("t6_count_b", 32'(bus.move_count), 32'd12);
      check_val("t6_nmoves_b", 32'(rx.size()), 32'd12);
      for (int i = 0; i < 12; i++) check_val("t6_mv", rx_at(i), 32'(400 + i));
      check_val("t6_nreads", 32'(rd_log.size()), 32'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
